// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through its start/data/busy handshake.
// Queued bytes leave in order; a popped byte is always allowed to finish.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy
);

  localparam int                  DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_r;
  state_t                stateNext_s;
  logic [7:0]            mem_r [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wrPtr_r;
  logic [DEPTH_LOG2-1:0] rdPtr_r;
  logic                  wrAccept_s;
  logic                  wrDrop_s;
  logic                  pop_s;
  logic                  txStartNext_s;
  logic [7:0]            txDataNext_s;
  logic [DEPTH_LOG2:0]   countNext_s;

  // Write decode, handshake FSM next state and queue-depth arithmetic.
  always_comb begin
    wrAccept_s    = wr_en & ~flush & ~full;
    wrDrop_s      = wr_en & ~flush & full;
    stateNext_s   = state_r;
    txStartNext_s = 1'b0;
    txDataNext_s  = tx_data;
    pop_s         = 1'b0;
    countNext_s   = count;

    case (state_r)
      IDLE: begin
        if (!empty && !tx_busy && !flush) begin
          pop_s         = 1'b1;
          stateNext_s   = SEND;
          txStartNext_s = 1'b1;
          txDataNext_s  = mem_r[rdPtr_r];
        end else begin
          stateNext_s   = IDLE;
        end
      end
      SEND: begin
        if (tx_busy) begin
          stateNext_s   = DRAIN;
          txStartNext_s = 1'b0;
        end else begin
          stateNext_s   = SEND;
          txStartNext_s = 1'b1;
        end
      end
      DRAIN: begin
        if (!tx_busy) begin
          stateNext_s = IDLE;
        end else begin
          stateNext_s = DRAIN;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase

    // Flush only discards queued bytes; the FSM keeps any byte already popped.
    if (flush) begin
      countNext_s = CNT_ZERO;
    end else if (wrAccept_s && !pop_s) begin
      countNext_s = count + CNT_ONE;
    end else if (!wrAccept_s && pop_s) begin
      countNext_s = count - CNT_ONE;
    end else begin
      countNext_s = count;
    end
  end

  // Control state, pointers, depth flags and transmitter outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      wrPtr_r  <= PTR_ZERO;
      rdPtr_r  <= PTR_ZERO;
      count    <= CNT_ZERO;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state_r  <= stateNext_s;
      tx_start <= txStartNext_s;
      tx_data  <= txDataNext_s;
      count    <= countNext_s;
      full     <= (countNext_s == CNT_FULL);
      empty    <= (countNext_s == CNT_ZERO);
      if (flush) begin
        wrPtr_r  <= PTR_ZERO;
        rdPtr_r  <= PTR_ZERO;
        overflow <= 1'b0;
      end else begin
        if (wrAccept_s) begin
          wrPtr_r <= wrPtr_r + PTR_ONE;
        end
        if (pop_s) begin
          rdPtr_r <= rdPtr_r + PTR_ONE;
        end
        if (wrDrop_s) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Byte storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wrAccept_s) begin
      mem_r[wrPtr_r] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo with a behavioural transmitter and a
// queue-based reference of the byte stream that must reach it.
module tb_uart_tx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          flush = 1'b0;
  logic          full;
  logic          empty;
  logic [DL:0]   count;
  logic          overflow;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;

  int            numChecks = 0;
  int            numErrors = 0;

  int            mCnt = 0;
  int            busyLen = 3;
  bit            randBusy = 1'b0;
  bit            forceBusy = 1'b0;
  logic [7:0]    rxQ[$];
  logic          startPrev = 1'b0;
  logic          busyPrev = 1'b0;

  uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  assign tx_busy = (mCnt != 0) || forceBusy;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numErrors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transmitter: latches on start when not busy, then stays busy for a while.
  always @(posedge clk) begin
    if (mCnt != 0) begin
      mCnt <= mCnt - 1;
    end else if (tx_start && !forceBusy) begin
      rxQ.push_back(tx_data);
      mCnt <= randBusy ? int'($urandom_range(1, 6)) : busyLen;
    end
  end

  always @(posedge clk) begin
    startPrev <= tx_start;
    busyPrev  <= tx_busy;
  end

  // A start may only rise after an edge at which busy was low.
  always @(negedge clk) begin
    if (!rst && tx_start && !startPrev) begin
      checkEq("startWhileBusy", 32'(busyPrev), 32'h0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitDrain();
    int quiet = 0;
    int guard = 0;
    while (quiet < 4 && guard < 2000) begin
      cyc();
      guard++;
      if (count == 0 && !tx_busy && !tx_start) quiet++;
      else quiet = 0;
    end
    checkEq("drainDone", 32'(quiet >= 4), 32'h1);
  endtask

  task automatic fillForced(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      cyc();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int nW;
    int bound;
    int guard;

    // Reset state
    repeat (2) @(negedge clk);
    checkEq("rstCount", 32'(count), 32'h0);
    checkEq("rstEmpty", 32'(empty), 32'h1);
    checkEq("rstFull", 32'(full), 32'h0);
    checkEq("rstOvf", 32'(overflow), 32'h0);
    checkEq("rstStart", 32'(tx_start), 32'h0);
    checkEq("rstData", 32'(tx_data), 32'h0);
    rst = 1'b0;
    cyc();

    // Single byte latency, then a back-to-back byte queued during busy
    busyLen = 20;
    wr_en = 1'b1; wr_data = 8'hA5;
    cyc();
    wr_en = 1'b0;
    checkEq("e0Count", 32'(count), 32'h1);
    checkEq("e0Start", 32'(tx_start), 32'h0);
    cyc();
    checkEq("e1Start", 32'(tx_start), 32'h1);
    checkEq("e1Data", 32'(tx_data), 32'hA5);
    checkEq("e1Count", 32'(count), 32'h0);
    checkEq("e1Empty", 32'(empty), 32'h1);
    cyc();
    checkEq("e2Start", 32'(tx_start), 32'h1);
    checkEq("e2Busy", 32'(tx_busy), 32'h1);
    cyc();
    checkEq("e3Start", 32'(tx_start), 32'h0);
    wr_en = 1'b1; wr_data = 8'h5A;
    cyc();
    wr_en = 1'b0;
    checkEq("b2bCount", 32'(count), 32'h1);
    guard = 0;
    while (tx_busy && guard < 100) begin
      cyc();
      guard++;
    end
    checkEq("busyFell", 32'(tx_busy), 32'h0);
    checkEq("b2bStart0", 32'(tx_start), 32'h0);
    cyc();
    checkEq("b2bStart1", 32'(tx_start), 32'h0);
    cyc();
    checkEq("b2bStart2", 32'(tx_start), 32'h1);
    checkEq("b2bData", 32'(tx_data), 32'h5A);
    waitDrain();
    checkEq("singleLen", 32'(rxQ.size()), 32'd2);
    if (rxQ.size() == 2) begin
      checkEq("single0", 32'(rxQ[0]), 32'hA5);
      checkEq("single1", 32'(rxQ[1]), 32'h5A);
    end

    // Ordering and pointer wrap with random pacing and busy lengths
    rxQ.delete();
    randBusy = 1'b1;
    nW = 0;
    guard = 0;
    while (nW < 40 && guard < 5000) begin
      bound = nW - rxQ.size();
      checkEq("cntRange", 32'(int'(count) == bound || int'(count) == bound - 1), 32'h1);
      if (bound < DEPTH && $urandom_range(0, 3) != 0) begin
        wr_en   = 1'b1;
        wr_data = 8'(nW);
        nW++;
      end else begin
        wr_en = 1'b0;
      end
      cyc();
      guard++;
    end
    wr_en = 1'b0;
    waitDrain();
    randBusy = 1'b0;
    checkEq("ordLen", 32'(rxQ.size()), 32'd40);
    for (int i = 0; i < rxQ.size() && i < 40; i++) begin
      checkEq("ordData", 32'(rxQ[i]), 32'(i));
    end
    checkEq("ordOvf", 32'(overflow), 32'h0);

    // Overflow while the transmitter is held busy
    rxQ.delete();
    busyLen = 3;
    forceBusy = 1'b1;
    fillForced(8'h10, 16);
    checkEq("ovfFull16", 32'(full), 32'h1);
    checkEq("ovfCount16", 32'(count), 32'd16);
    checkEq("ovfFlag16", 32'(overflow), 32'h0);
    fillForced(8'h20, 1);
    checkEq("ovfCount17", 32'(count), 32'd16);
    checkEq("ovfFlag17", 32'(overflow), 32'h1);
    forceBusy = 1'b0;
    waitDrain();
    checkEq("ovfLen", 32'(rxQ.size()), 32'd16);
    for (int i = 0; i < rxQ.size() && i < 16; i++) begin
      checkEq("ovfData", 32'(rxQ[i]), 32'(8'h10 + 8'(i)));
    end
    checkEq("ovfSticky", 32'(overflow), 32'h1);
    checkEq("ovfEmpty", 32'(empty), 32'h1);

    // Full FIFO: the pop edge coincides with a write that must be dropped
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    checkEq("flushOvfClr", 32'(overflow), 32'h0);
    rxQ.delete();
    forceBusy = 1'b1;
    fillForced(8'h40, 16);
    checkEq("fpFull", 32'(full), 32'h1);
    forceBusy = 1'b0;
    wr_en = 1'b1; wr_data = 8'hEE;
    cyc();
    wr_en = 1'b0;
    checkEq("fpCount", 32'(count), 32'd15);
    checkEq("fpOvf", 32'(overflow), 32'h1);
    checkEq("fpFullAfter", 32'(full), 32'h0);
    checkEq("fpStart", 32'(tx_start), 32'h1);
    checkEq("fpData", 32'(tx_data), 32'h40);
    waitDrain();
    checkEq("fpLen", 32'(rxQ.size()), 32'd16);
    for (int i = 0; i < rxQ.size() && i < 16; i++) begin
      checkEq("fpRx", 32'(rxQ[i]), 32'(8'h40 + 8'(i)));
    end

    // Flush while the first of five bytes is in flight
    rxQ.delete();
    busyLen = 8;
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'hA0 + 8'(i);
      cyc();
    end
    wr_en = 1'b0;
    checkEq("flPreCount", 32'(count), 32'd4);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    cyc();
    flush = 1'b0; wr_en = 1'b0;
    checkEq("flCount", 32'(count), 32'h0);
    checkEq("flEmpty", 32'(empty), 32'h1);
    checkEq("flOvf", 32'(overflow), 32'h0);
    waitDrain();
    checkEq("flLen", 32'(rxQ.size()), 32'd1);
    if (rxQ.size() > 0) checkEq("flFirst", 32'(rxQ[0]), 32'hA0);

    // Asynchronous reset mid-byte, then a byte queued while busy persists
    forceBusy = 1'b1;
    fillForced(8'h60, 17);
    checkEq("preRstOvf", 32'(overflow), 32'h1);
    forceBusy = 1'b0;
    busyLen = 20;
    repeat (3) cyc();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkEq("arCount", 32'(count), 32'h0);
    checkEq("arEmpty", 32'(empty), 32'h1);
    checkEq("arFull", 32'(full), 32'h0);
    checkEq("arOvf", 32'(overflow), 32'h0);
    checkEq("arStart", 32'(tx_start), 32'h0);
    checkEq("arData", 32'(tx_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rxQ.delete();
    wr_en = 1'b1; wr_data = 8'hC3;
    cyc();
    wr_en = 1'b0;
    checkEq("arQueued", 32'(count), 32'h1);
    guard = 0;
    while (tx_busy && guard < 100) begin
      checkEq("arNoStart", 32'(tx_start), 32'h0);
      cyc();
      guard++;
    end
    waitDrain();
    checkEq("arLen", 32'(rxQ.size()), 32'd1);
    if (rxQ.size() > 0) checkEq("arByte", 32'(rxQ[0]), 32'hC3);

    $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
    $finish;
  end

endmodule
